draw_keeper_screen: RTL

// - Downstream consumer of the keeper screen image ROM: converts the incoming VGA timing stream into ROM addresses and overlays returned pixels.
// - Sits in the VGA pixel chain between timing/background and the final VGA output mux.
// - Delays all timing signals to match address-register + ROM latency.
// - A frame-synchronous FSM switches the overlay on/off only at vblank, so a frame never mixes two sources.

---
 rtl/draw_keeper_screen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/draw_keeper_screen.sv
// Keeper screen overlay: VGA stream -> ROM address, 3-clk aligned output with ROM pixel overlay.
// No backpressure (free-running pixel pipeline); KEEPER_KEY_EN enables KEY_RGB transparency.
module draw_keeper_screen #(
  parameter int IMG_W      = 1024,
  parameter int IMG_H      = 768,
  parameter int COORD_BITS = 10
`ifdef KEEPER_KEY_EN
  , parameter logic [11:0] KEY_RGB = 12'hF0F
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [10:0]               hcount_in,
  input  logic [10:0]               vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [11:0]               rgb_in,
  output logic [2*COORD_BITS-1:0]   rom_addr,
  input  logic [11:0]               rom_data,
  output logic [10:0]               hcount_out,
  output logic [10:0]               vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [11:0]               rgb_out,
  output logic                      active
);

  typedef enum logic [1:0] {
    S_OFF,
    S_PENDING_ON,
    S_ON,
    S_PENDING_OFF
  } state_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        show;
  } side_t;

  state_t state, state_nxt;
  logic   vblnk_prev;
  logic   vblank_start;
  logic   in_image;
  logic   draw_rom;
  side_t  s1, s2;

  assign vblank_start = vblnk_in & ~vblnk_prev;
  assign active       = (state == S_ON) || (state == S_PENDING_OFF);
  assign in_image     = ({1'b0, hcount_in} < 12'(IMG_W)) && ({1'b0, vcount_in} < 12'(IMG_H));

  // Edge detector only tracks the input, so it keeps sampling through reset.
  always_ff @(posedge clk) begin
    vblnk_prev <= vblnk_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_OFF;
    else     state <= state_nxt;
  end

  // Enable changes win over vblank_start in the same clock.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:         if (enable) state_nxt = S_PENDING_ON;
      S_PENDING_ON:  if (!enable) state_nxt = S_OFF;
                     else if (vblank_start) state_nxt = S_ON;
      S_ON:          if (!enable) state_nxt = S_PENDING_OFF;
      S_PENDING_OFF: if (enable) state_nxt = S_ON;
                     else if (vblank_start) state_nxt = S_OFF;
      default:       state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    draw_rom = s2.show;
`ifdef KEEPER_KEY_EN
    if (rom_data == KEY_RGB) draw_rom = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      s1         <= '0;
      s2         <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      rom_addr  <= {vcount_in[COORD_BITS-1:0], hcount_in[COORD_BITS-1:0]};
      s1.hcount <= hcount_in;
      s1.vcount <= vcount_in;
      s1.hsync  <= hsync_in;
      s1.vsync  <= vsync_in;
      s1.hblnk  <= hblnk_in;
      s1.vblnk  <= vblnk_in;
      s1.rgb    <= rgb_in;
      s1.show   <= active && in_image;
      // s2 lines up with rom_data for the address registered alongside s1.
      s2         <= s1;
      hcount_out <= s2.hcount;
      vcount_out <= s2.vcount;
      hsync_out  <= s2.hsync;
      vsync_out  <= s2.vsync;
      hblnk_out  <= s2.hblnk;
      vblnk_out  <= s2.vblnk;
      if (s2.hblnk || s2.vblnk) rgb_out <= 12'h000;
      else if (draw_rom)        rgb_out <= rom_data;
      else                      rgb_out <= s2.rgb;
    end
  end

endmodule
